vc_tx_scheduler: RTL and testbench

- Shares the single packet-processor send path (AXI write side -> NoC local input) among NumVC per-VC TX buffers.
- Picks one VC and locks the grant for the whole packet, so flits of different packets never interleave in the HEAD/BODY/TAIL stream.
- Sits between the per-VC AXI TX FIFOs and the packet processor's pkt_out request/response interface.

---
 rtl/ravenoc_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/vc_tx_scheduler.sv | 125 ++++++++++++
 tb/tb_vc_tx_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared defaults and scheduler state encoding for the NoC TX send path.
package ravenoc_pkg;

    localparam int NumVCDefault         = 3;
    localparam int FlitDataWidthDefault = 32;
    localparam int PktWidthDefault      = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin search starting after ptr, or fixed
// priority where the highest requesting index wins.
module rr_arbiter #(
    parameter int N          = 3,
    parameter int RoundRobin = 1,
    localparam int IdxW      = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx
);

    logic found;
    int   cand;

    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        if (RoundRobin != 0) begin
            // Last served VC gets lowest priority next time
            for (int k = 1; k <= N; k++) begin
                cand = int'(ptr) + k;
                if (cand >= N) cand = cand - N;
                if (!found && req[cand]) begin
                    found     = 1'b1;
                    grant_idx = IdxW'(cand);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) grant_idx = IdxW'(i);
            end
        end
        grant = '0;
        if (|req) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/vc_tx_scheduler.sv
// Shares the packet-processor send path among per-VC TX FIFOs, holding the
// grant for a whole packet so HEAD/BODY/TAIL flits never interleave.
module vc_tx_scheduler
    import ravenoc_pkg::*;
#(
    parameter int NumVC         = NumVCDefault,
    parameter int FlitDataWidth = FlitDataWidthDefault,
    parameter int PktWidth      = PktWidthDefault,
    parameter int RoundRobin    = 1,
    localparam int IdxW         = $clog2(NumVC)
) (
    input  logic                           clk_axi,
    input  logic                           arst_axi,
    input  logic [NumVC-1:0]               vc_valid_i,
    input  logic [NumVC*FlitDataWidth-1:0] vc_flit_i,
    input  logic [NumVC*PktWidth-1:0]      vc_pkt_sz_i,
    output logic [NumVC-1:0]               vc_ready_o,
    output logic                           pkt_valid_o,
    output logic [FlitDataWidth-1:0]       pkt_flit_o,
    output logic [IdxW-1:0]                pkt_vc_id_o,
    output logic [PktWidth-1:0]            pkt_sz_o,
    input  logic                           pkt_ready_i,
    output logic                           busy_o,
    output logic [IdxW-1:0]                grant_o
);

    sched_state_t         state_ff, state_nxt;
    logic [IdxW-1:0]      grant_ff, grant_nxt;
    logic [IdxW-1:0]      rr_ptr_ff, rr_ptr_nxt;
    logic [PktWidth-1:0]  remaining_ff, remaining_nxt;

    logic [NumVC-1:0]         arb_onehot;
    logic [IdxW-1:0]          arb_idx;
    logic [IdxW-1:0]          sel_idx;
    logic [FlitDataWidth-1:0] sel_flit;
    logic [PktWidth-1:0]      sel_sz;
    logic                     locked;
    logic                     accept;

    rr_arbiter #(
        .N          (NumVC),
        .RoundRobin (RoundRobin)
    ) u_arb (
        .req       (vc_valid_i),
        .ptr       (rr_ptr_ff),
        .grant     (arb_onehot),
        .grant_idx (arb_idx)
    );

    assign locked  = (state_ff == LOCKED);
    assign sel_idx = locked ? grant_ff : arb_idx;

    always_comb begin
        sel_flit = '0;
        sel_sz   = '0;
        for (int i = 0; i < NumVC; i++) begin
            if (sel_idx == IdxW'(i)) begin
                sel_flit = vc_flit_i[i*FlitDataWidth +: FlitDataWidth];
                sel_sz   = vc_pkt_sz_i[i*PktWidth +: PktWidth];
            end
        end
    end

    // Valid is formed from requests only, never from pkt_ready_i
    assign pkt_valid_o = locked ? vc_valid_i[grant_ff] : (|vc_valid_i);
    assign accept      = pkt_valid_o & pkt_ready_i;
    assign pkt_flit_o  = sel_flit;
    assign pkt_vc_id_o = sel_idx;
    assign pkt_sz_o    = locked ? remaining_ff : sel_sz;
    assign busy_o      = locked;
    assign grant_o     = sel_idx;

    always_comb begin
        vc_ready_o = '0;
        if (accept) begin
            if (locked) vc_ready_o[grant_ff] = 1'b1;
            else        vc_ready_o = arb_onehot;
        end
    end

    always_comb begin
        state_nxt     = state_ff;
        grant_nxt     = grant_ff;
        remaining_nxt = remaining_ff;
        rr_ptr_nxt    = rr_ptr_ff;
        case (state_ff)
            IDLE: begin
                if (accept) begin
                    if (sel_sz != '0) begin
                        state_nxt     = LOCKED;
                        grant_nxt     = arb_idx;
                        remaining_nxt = sel_sz;
                    end else begin
                        rr_ptr_nxt = arb_idx;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    remaining_nxt = remaining_ff - PktWidth'(1);
                    if (remaining_ff == PktWidth'(1)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = grant_ff;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            state_ff     <= IDLE;
            grant_ff     <= '0;
            remaining_ff <= '0;
            rr_ptr_ff    <= '0;
        end else begin
            state_ff     <= state_nxt;
            grant_ff     <= grant_nxt;
            remaining_ff <= remaining_nxt;
            rr_ptr_ff    <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_vc_tx_scheduler.sv
// Directed bench for vc_tx_scheduler: round-robin instance plus a fixed-priority
// instance fed from the same inputs.
`timescale 1ns/1ps
module tb_vc_tx_scheduler;

    localparam int NV = 3;
    localparam int FW = 32;
    localparam int PW = 8;
    localparam int IW = 2;

    localparam logic [FW-1:0] F0 = 32'hF000_0A00;
    localparam logic [FW-1:0] F1 = 32'hF000_0B11;
    localparam logic [FW-1:0] F2 = 32'hF000_0C22;

    logic              clk_axi  = 1'b0;
    logic              arst_axi = 1'b1;
    logic [NV-1:0]     vc_valid = '0;
    logic [NV*FW-1:0]  vc_flit  = '0;
    logic [NV*PW-1:0]  vc_sz    = '0;
    logic              pkt_ready = 1'b1;

    logic [NV-1:0] vc_ready, fp_vc_ready;
    logic          pkt_valid, fp_pkt_valid;
    logic [FW-1:0] pkt_flit, fp_pkt_flit;
    logic [IW-1:0] pkt_vc_id, fp_pkt_vc_id;
    logic [PW-1:0] pkt_sz, fp_pkt_sz;
    logic          busy, fp_busy;
    logic [IW-1:0] grant, fp_grant;

    int n_tests = 0;
    int n_fail  = 0;

    vc_tx_scheduler #(.NumVC(NV), .FlitDataWidth(FW), .PktWidth(PW), .RoundRobin(1)) dut (
        .clk_axi(clk_axi), .arst_axi(arst_axi), .vc_valid_i(vc_valid), .vc_flit_i(vc_flit),
        .vc_pkt_sz_i(vc_sz), .vc_ready_o(vc_ready), .pkt_valid_o(pkt_valid), .pkt_flit_o(pkt_flit),
        .pkt_vc_id_o(pkt_vc_id), .pkt_sz_o(pkt_sz), .pkt_ready_i(pkt_ready), .busy_o(busy),
        .grant_o(grant)
    );

    vc_tx_scheduler #(.NumVC(NV), .FlitDataWidth(FW), .PktWidth(PW), .RoundRobin(0)) dut_fp (
        .clk_axi(clk_axi), .arst_axi(arst_axi), .vc_valid_i(vc_valid), .vc_flit_i(vc_flit),
        .vc_pkt_sz_i(vc_sz), .vc_ready_o(fp_vc_ready), .pkt_valid_o(fp_pkt_valid),
        .pkt_flit_o(fp_pkt_flit), .pkt_vc_id_o(fp_pkt_vc_id), .pkt_sz_o(fp_pkt_sz),
        .pkt_ready_i(pkt_ready), .busy_o(fp_busy), .grant_o(fp_grant)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic cyc();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic set_vc(input int i, input logic v, input logic [FW-1:0] f, input logic [PW-1:0] s);
        vc_valid[i]        = v;
        vc_flit[i*FW +: FW] = f;
        vc_sz[i*PW +: PW]   = s;
    endtask

    task automatic reset_dut();
        arst_axi  = 1'b1;
        vc_valid  = '0;
        vc_flit   = '0;
        vc_sz     = '0;
        pkt_ready = 1'b1;
        cyc();
        arst_axi = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({pkt_valid, vc_ready, busy, grant} !== {1'b0, 3'b000, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_rr: got v/rdy/busy/gnt=%b/%b/%b/%0d want 0/000/0/0", pkt_valid, vc_ready, busy, grant);
        end
        n_tests++;
        if ({fp_pkt_valid, fp_vc_ready, fp_busy} !== {1'b0, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_fp: got v/rdy/busy=%b/%b/%b want 0/000/0", fp_pkt_valid, fp_vc_ready, fp_busy);
        end
        cyc();
        arst_axi = 1'b0;
        #1;
    endtask

    task automatic test_single();
        logic          eb;
        logic [PW-1:0] es;
        reset_dut();
        set_vc(1, 1'b1, F1, 8'd3);
        #1;
        for (int c = 0; c < 4; c++) begin
            eb = (c > 0);
            es = (c == 0) ? 8'd3 : PW'(4 - c);
            n_tests++;
            if ({pkt_valid, vc_ready, busy, grant, pkt_sz, pkt_flit} !== {1'b1, 3'b010, eb, 2'd1, es, F1}) begin
                n_fail++;
                $display("FAIL single c%0d: got v=%b rdy=%b busy=%b gnt=%0d sz=%0d flit=%h want 1 010 %b 1 %0d %h",
                         c, pkt_valid, vc_ready, busy, grant, pkt_sz, pkt_flit, eb, es, F1);
            end
            cyc();
        end
        set_vc(1, 1'b0, F1, 8'd0);
        #1;
        n_tests++;
        if ({pkt_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: got v=%b busy=%b want 0 0", pkt_valid, busy);
        end
    endtask

    task automatic test_rr_two();
        int            ids[6] = '{2, 2, 2, 0, 0, 0};
        logic          eb;
        logic [NV-1:0] er;
        reset_dut();
        set_vc(0, 1'b1, F0, 8'd2);
        set_vc(2, 1'b1, F2, 8'd2);
        #1;
        for (int c = 0; c < 6; c++) begin
            eb = (c % 3) != 0;
            er = NV'(1 << ids[c]);
            n_tests++;
            if ({pkt_vc_id, vc_ready, busy} !== {IW'(ids[c]), er, eb}) begin
                n_fail++;
                $display("FAIL rr_two c%0d: got id=%0d rdy=%b busy=%b want %0d %b %b",
                         c, pkt_vc_id, vc_ready, busy, ids[c], er, eb);
            end
            n_tests++;
            if ({fp_pkt_vc_id, fp_vc_ready, fp_pkt_flit} !== {2'd2, 3'b100, F2}) begin
                n_fail++;
                $display("FAIL fixed_prio c%0d: got id=%0d rdy=%b flit=%h want 2 100 %h",
                         c, fp_pkt_vc_id, fp_vc_ready, fp_pkt_flit, F2);
            end
            cyc();
        end
    endtask

    task automatic test_bubble();
        logic          v;
        logic [NV-1:0] er;
        reset_dut();
        set_vc(0, 1'b1, F0, 8'd4);
        #1;
        n_tests++;
        if ({pkt_valid, vc_ready, busy, grant} !== {1'b1, 3'b001, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL bubble_head: got v=%b rdy=%b busy=%b gnt=%0d want 1 001 0 0", pkt_valid, vc_ready, busy, grant);
        end
        cyc();
        set_vc(1, 1'b1, F1, 8'd0);
        for (int c = 1; c <= 6; c++) begin
            v  = !(c == 2 || c == 3);
            vc_valid[0] = v;
            er = v ? 3'b001 : 3'b000;
            #1;
            n_tests++;
            if ({pkt_valid, vc_ready, busy, grant} !== {v, er, 1'b1, 2'd0}) begin
                n_fail++;
                $display("FAIL bubble c%0d: got v=%b rdy=%b busy=%b gnt=%0d want %b %b 1 0",
                         c, pkt_valid, vc_ready, busy, grant, v, er);
            end
            cyc();
        end
        vc_valid[0] = 1'b0;
        #1;
        n_tests++;
        if ({pkt_valid, vc_ready, busy, grant} !== {1'b1, 3'b010, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL bubble_after: got v=%b rdy=%b busy=%b gnt=%0d want 1 010 0 1", pkt_valid, vc_ready, busy, grant);
        end
        cyc();
    endtask

    task automatic test_stall();
        logic          rdy[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [PW-1:0] es[5]  = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1};
        logic          eb[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [NV-1:0] er;
        reset_dut();
        set_vc(2, 1'b1, F2, 8'd2);
        for (int c = 0; c < 5; c++) begin
            pkt_ready = rdy[c];
            er = rdy[c] ? 3'b100 : 3'b000;
            #1;
            n_tests++;
            if ({pkt_valid, vc_ready, busy, pkt_vc_id, pkt_sz, pkt_flit} !== {1'b1, er, eb[c], 2'd2, es[c], F2}) begin
                n_fail++;
                $display("FAIL stall c%0d: got v=%b rdy=%b busy=%b id=%0d sz=%0d flit=%h want 1 %b %b 2 %0d %h",
                         c, pkt_valid, vc_ready, busy, pkt_vc_id, pkt_sz, pkt_flit, er, eb[c], es[c], F2);
            end
            cyc();
        end
        set_vc(2, 1'b0, F2, 8'd0);
        pkt_ready = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int            ids[4] = '{1, 2, 0, 1};
        logic [NV-1:0] er;
        reset_dut();
        set_vc(0, 1'b1, F0, 8'd0);
        set_vc(1, 1'b1, F1, 8'd0);
        set_vc(2, 1'b1, F2, 8'd0);
        #1;
        for (int c = 0; c < 4; c++) begin
            er = NV'(1 << ids[c]);
            n_tests++;
            if ({pkt_vc_id, grant, vc_ready, busy} !== {IW'(ids[c]), IW'(ids[c]), er, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b c%0d: got id=%0d gnt=%0d rdy=%b busy=%b want %0d %0d %b 0",
                         c, pkt_vc_id, grant, vc_ready, busy, ids[c], ids[c], er);
            end
            cyc();
        end
    endtask

    task automatic test_max_len();
        logic [PW-1:0] es;
        reset_dut();
        set_vc(0, 1'b1, F0, 8'hFF);
        #1;
        n_tests++;
        if ({busy, pkt_sz} !== {1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL maxlen_head: got busy=%b sz=%0d want 0 255", busy, pkt_sz);
        end
        cyc();
        for (int c = 1; c <= 255; c++) begin
            es = PW'(256 - c);
            n_tests++;
            if ({busy, pkt_sz, vc_ready} !== {1'b1, es, 3'b001}) begin
                n_fail++;
                $display("FAIL maxlen c%0d: got busy=%b sz=%0d rdy=%b want 1 %0d 001", c, busy, pkt_sz, vc_ready, es);
            end
            cyc();
        end
        vc_valid = '0;
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL maxlen_end: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        set_vc(2, 1'b1, F2, 8'd0);
        #1;
        cyc();
        set_vc(2, 1'b0, F2, 8'd0);
        set_vc(1, 1'b1, F1, 8'd3);
        #1;
        cyc();
        cyc();
        n_tests++;
        if ({busy, pkt_sz, grant} !== {1'b1, 8'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL rstmid_pre: got busy=%b sz=%0d gnt=%0d want 1 2 1", busy, pkt_sz, grant);
        end
        arst_axi = 1'b1;
        #1;
        n_tests++;
        if ({busy, pkt_valid, grant} !== {1'b0, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy=%b v=%b gnt=%0d want 0 1 1", busy, pkt_valid, grant);
        end
        set_vc(1, 1'b0, F1, 8'd0);
        set_vc(0, 1'b1, F0, 8'd0);
        set_vc(2, 1'b1, F2, 8'd0);
        @(negedge clk_axi);
        arst_axi = 1'b0;
        #1;
        n_tests++;
        if ({busy, grant, pkt_vc_id, pkt_flit} !== {1'b0, 2'd2, 2'd2, F2}) begin
            n_fail++;
            $display("FAIL rstmid_release: got busy=%b gnt=%0d id=%0d flit=%h want 0 2 2 %h", busy, grant, pkt_vc_id, pkt_flit, F2);
        end
        cyc();
        n_tests++;
        if ({busy, grant, vc_ready} !== {1'b0, 2'd0, 3'b001}) begin
            n_fail++;
            $display("FAIL rstmid_next: got busy=%b gnt=%0d rdy=%b want 0 0 001", busy, grant, vc_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_two();
        test_bubble();
        test_stall();
        test_back_to_back();
        test_max_len();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
